// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// Operands in on a valid/ready stream, result out on a valid/ready stream held until accepted.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             V
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;

  logic a_bit, b_bit, d_bit, borrow_next;

  always_comb begin
    // Operands shift right, so bit 0 always holds the bit currently being processed.
    a_bit       = a_q[0];
    b_bit       = b_q[0];
    d_bit       = a_bit ^ b_bit ^ borrow_q;
    borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);

    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bout_d   = bout_q;
    v_d      = v_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          cnt_d    = '0;
          res_d    = '0;
          bout_d   = 1'b0;
          v_d      = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = borrow_next;
        res_d    = {d_bit, res_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // On the last bit, a_bit/b_bit are the operand MSBs and d_bit is the result MSB.
          bout_d  = borrow_next;
          v_d     = (a_bit ^ b_bit) & (d_bit ^ a_bit);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bout_q   <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      bout_q   <= bout_d;
      v_q      <= v_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Diff      = res_q;
  assign Bout      = bout_q;
  assign V         = v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=4): directed cases, backpressure, mid-operation reset, random operands.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         V;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff), .Bout(Bout), .V(V)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [W+1:0] model(input int a, input int b, input int bin);
    int d, sa, sb, sd;
    logic [W-1:0] diff;
    logic bout, v;
    d    = a - b - bin;
    diff = W'(d & ((1 << W) - 1));
    bout = (a < b + bin);
    sa   = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sb   = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    sd   = sa - sb - bin;
    v    = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
    return {v, bout, diff};
  endfunction

  task automatic do_op(input string tag, input int a, input int b, input int bin, input int hold);
    logic [W+1:0] exp;
    int edges;
    exp = model(a, b, bin);
    @(negedge clk);
    chk({tag, ".in_ready_before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; A = W'(a); B = W'(b); Bin = 1'(bin);
    @(negedge clk);
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 20) begin
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      edges++;
    end
    chk({tag, ".latency"}, 32'(edges), 32'(W + 1));
    chk({tag, ".Diff"}, 32'(Diff), 32'(exp[W-1:0]));
    chk({tag, ".Bout"}, 32'(Bout), 32'(exp[W]));
    chk({tag, ".V"}, 32'(V), 32'(exp[W+1]));
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid = 1'b1; A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      @(negedge clk);
      chk({tag, ".hold"}, {out_valid, in_ready, V, Bout, 28'(Diff)},
          {1'b1, 1'b0, exp[W+1], exp[W], 28'(exp[W-1:0])});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".after_hs"}, {30'(out_valid), in_ready, 1'b0}, {30'd0, 1'b1, 1'b0});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; A = 4'd7; B = 4'd2; Bin = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.outputs", {Diff, Bout, V}, 32'd0);

    do_op("a3b1", 3, 1, 0, 0);
    do_op("a1b3", 1, 3, 0, 0);
    do_op("c_a_bin", 12, 10, 1, 0);
    do_op("wrap", 0, 15, 1, 0);
    do_op("ovf", 8, 1, 0, 0);
    do_op("bp", 9, 6, 1, 3);

    // Reset after two bit edges of an operation.
    @(negedge clk);
    in_valid = 1'b1; A = 4'd9; B = 4'd4; Bin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.state", {in_ready, out_valid, Bout, V, 28'(Diff)}, {1'b1, 1'b0, 1'b0, 1'b0, 28'd0});
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("midrst.no_result", 32'(seen), 32'd0);
    end
    do_op("post_rst", 5, 2, 0, 0);

    for (int n = 0; n < 25; n++) begin
      do_op("rand", int'($urandom_range(15)), int'($urandom_range(15)),
            int'($urandom_range(1)), int'($urandom_range(2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
